// File: rtl/page_walker.sv
// page_walker
//   Hardware page-table walker and miss responder for TLB refill. Accepts one
//   translation miss at a time, walks a LEVELS-deep radix page table through a
//   single-outstanding memory read port, and returns either the translated
//   physical address or a fault.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_*             miss request (va, pcid) plus the root table base for it
//   mem_req_*         PTE read request (byte address)
//   mem_resp_*        PTE read data (one response per accepted request)
//   resp_*            translation result back to the TLB
//   dbg_state         current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid source holds valid and its payload stable until that
// edge. mem_resp_valid has no ready; it is only looked at in WAIT.
module page_walker #(
  parameter int SADDR  = 64,
  parameter int SPAGE  = 12,
  parameter int SPCID  = 12,
  parameter int LEVELS = 4,
  parameter int SIDX   = 9,
  parameter int SPTE   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SADDR-1:0] req_va,
  input  logic [SPCID-1:0] req_pcid,
  input  logic [SADDR-1:0] root_base,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [SADDR-1:0] mem_addr,
  input  logic             mem_resp_valid,
  input  logic [SPTE-1:0]  mem_resp_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [SADDR-1:0] resp_va,
  output logic [SPCID-1:0] resp_pcid,
  output logic [SADDR-1:0] resp_pa,
  output logic             resp_fault,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int LVLW      = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int STRIDE_SH = $clog2(SPTE / 8);
  localparam logic [SADDR-1:0] IDX_MASK = (SADDR'(1) << SIDX) - SADDR'(1);
  localparam logic [LVLW-1:0]  TOP_LVL  = LVLW'(LEVELS - 1);

  state_t           state;
  logic [SADDR-1:0] va_q;
  logic [SPCID-1:0] pcid_q;
  logic [LVLW-1:0]  lvl;
  logic [SADDR-1:0] next_base;
  logic             unused_pte;

  // PTE byte address for level lvl: table base plus the va index scaled by the
  // PTE stride. Wraps modulo 2^SADDR by construction.
  function automatic logic [SADDR-1:0] pte_addr(input logic [SADDR-1:0] base,
                                                 input logic [SADDR-1:0] va,
                                                 input logic [LVLW-1:0]  l);
    logic [SADDR-1:0] idx;
    idx = (va >> (SPAGE + SIDX * int'(l))) & IDX_MASK;
    return base + (idx << STRIDE_SH);
  endfunction

  // Next-level table base (or final page frame) carried by the PTE.
  assign next_base  = {mem_resp_data[SADDR-1:SPAGE], {SPAGE{1'b0}}};
  // Only the valid bit and the frame field of a PTE carry meaning.
  assign unused_pte = ^mem_resp_data;
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      resp_valid    <= 1'b0;
      resp_va       <= '0;
      resp_pcid     <= '0;
      resp_pa       <= '0;
      resp_fault    <= 1'b0;
      va_q          <= '0;
      pcid_q        <= '0;
      lvl           <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            va_q          <= req_va;
            pcid_q        <= req_pcid;
            lvl           <= TOP_LVL;
            // First address is formed here so mem_addr is a clean register
            // output from the first ISSUE cycle.
            mem_addr      <= pte_addr(root_base, req_va, TOP_LVL);
            mem_req_valid <= 1'b1;
            req_ready     <= 1'b0;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            if (!mem_resp_data[0]) begin
              resp_valid <= 1'b1;
              resp_va    <= va_q;
              resp_pcid  <= pcid_q;
              resp_pa    <= '0;
              resp_fault <= 1'b1;
              state      <= S_RESP;
            end else if (lvl != '0) begin
              lvl           <= lvl - LVLW'(1);
              mem_addr      <= pte_addr(next_base, va_q, lvl - LVLW'(1));
              mem_req_valid <= 1'b1;
              state         <= S_ISSUE;
            end else begin
              resp_valid <= 1'b1;
              resp_va    <= va_q;
              resp_pcid  <= pcid_q;
              resp_pa    <= {mem_resp_data[SADDR-1:SPAGE], va_q[SPAGE-1:0]};
              resp_fault <= 1'b0;
              state      <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_page_walker.sv
// tb_page_walker
//   Directed bench for page_walker with default parameters (64-bit addresses,
//   4 levels). A small memory model answers each accepted PTE read one cycle
//   later from an address-keyed image and logs every accepted address.
module tb_page_walker;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_va;
  logic [11:0] req_pcid;
  logic [63:0] root_base;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_va;
  logic [11:0] resp_pcid;
  logic [63:0] resp_pa;
  logic        resp_fault;
  logic [1:0]  dbg_state;

  int vectors;
  int miscompares;

  logic [63:0] mem_img [logic [63:0]];
  logic [63:0] addr_log[$];
  logic [63:0] exp_q[$];
  logic        mem_hold;
  logic        inject_stale;

  page_walker dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va),
    .req_pcid(req_pcid), .root_base(root_base),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_va(resp_va),
    .resp_pcid(resp_pcid), .resp_pa(resp_pa), .resp_fault(resp_fault),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- memory model ----------------
  // Samples the handshake at the edge, then drives the response 2ns later so
  // the walker sees it on the following edge.
  always @(posedge clk) begin
    logic        hs;
    logic [63:0] a;
    hs = rst_n && mem_req_valid && mem_req_ready;
    a  = mem_addr;
    if (hs) addr_log.push_back(a);
    #2;
    mem_resp_valid = 1'b0;
    if (inject_stale) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'h99001;
      inject_stale   = 1'b0;
    end else if (hs && !mem_hold) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_img.exists(a) ? mem_img[a] : 64'h0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_base_image();
    mem_img.delete();
    mem_img[64'h1000] = 64'h2001;
    mem_img[64'h2000] = 64'h3001;
    mem_img[64'h3010] = 64'h4001;
    mem_img[64'h4008] = 64'h99001;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the first negedge after the accept edge (cycle 1).
  task automatic start_req(input logic [63:0] va, input logic [11:0] pcid,
                           input logic [63:0] root);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_va    = va;
    req_pcid  = pcid;
    root_base = root;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Cycle count (1 = first cycle after accept) at which resp_valid is seen.
  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (!resp_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    vectors++;
    if ({mem_req_valid, resp_valid, resp_fault} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_valids: got %b want 000", {mem_req_valid, resp_valid, resp_fault});
    end
    vectors++;
    if ({mem_addr, resp_pa, resp_va, resp_pcid} !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h %h %h %h want 0", mem_addr, resp_pa, resp_va, resp_pcid);
    end
    vectors++;
    if (dbg_state !== 2'd0) begin
      miscompares++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
  endtask

  task automatic test_base_walk(input logic [63:0] va, input string tag);
    int cyc;
    load_base_image();
    addr_log.delete();
    exp_q = '{64'h1000, 64'h2000, 64'h3010, 64'h4008};
    start_req(va, 12'd5, 64'h1000);
    wait_resp(cyc);
    vectors++;
    if (cyc !== 9) begin
      miscompares++; $display("FAIL %s_latency: got %0d want 9", tag, cyc);
    end
    vectors++;
    if (resp_pa !== 64'h99ABC || resp_fault !== 1'b0) begin
      miscompares++; $display("FAIL %s_pa: got %h/%b want 99abc/0", tag, resp_pa, resp_fault);
    end
    vectors++;
    if (resp_pcid !== 12'd5 || resp_va !== va) begin
      miscompares++; $display("FAIL %s_echo: got %h/%h want %h/5", tag, resp_va, resp_pcid, va);
    end
    vectors++;
    if (addr_log.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL %s_nreads: got %0d want %0d", tag, addr_log.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && addr_log.size() > 0) begin
      logic [63:0] e, g;
      e = exp_q.pop_front();
      g = addr_log.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++; $display("FAIL %s_addr: got %h want %h", tag, g, e);
      end
    end
    consume();
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++; $display("FAIL %s_done: got valid=%b ready=%b want 0/1", tag, resp_valid, req_ready);
    end
  endtask

  task automatic test_fault();
    int cyc;
    load_base_image();
    mem_img[64'h3010] = 64'h4000;
    addr_log.delete();
    start_req(64'h401ABC, 12'd7, 64'h1000);
    wait_resp(cyc);
    vectors++;
    if (cyc !== 7) begin
      miscompares++; $display("FAIL fault_latency: got %0d want 7", cyc);
    end
    vectors++;
    if (resp_fault !== 1'b1 || resp_pa !== 64'h0) begin
      miscompares++; $display("FAIL fault_result: got %b/%h want 1/0", resp_fault, resp_pa);
    end
    vectors++;
    if (addr_log.size() !== 3) begin
      miscompares++; $display("FAIL fault_nreads: got %0d want 3", addr_log.size());
    end
    vectors++;
    if (resp_pcid !== 12'd7) begin
      miscompares++; $display("FAIL fault_pcid: got %h want 7", resp_pcid);
    end
    consume();
  endtask

  task automatic test_stall();
    int cyc;
    load_base_image();
    addr_log.delete();
    mem_req_ready = 1'b0;
    start_req(64'h401ABC, 12'd5, 64'h1000);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 64'h1000 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_mem_hold: got v=%b a=%h r=%b want 1/1000/0", mem_req_valid, mem_addr, req_ready);
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    wait_resp(cyc);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (resp_valid !== 1'b1 || resp_pa !== 64'h99ABC || resp_va !== 64'h401ABC ||
          resp_pcid !== 12'd5 || resp_fault !== 1'b0 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_resp_hold: got v=%b pa=%h va=%h pcid=%h f=%b r=%b", resp_valid,
                 resp_pa, resp_va, resp_pcid, resp_fault, req_ready);
      end
      @(negedge clk);
    end
    consume();
    vectors++;
    if (req_ready !== 1'b1 || addr_log.size() !== 4) begin
      miscompares++; $display("FAIL stall_done: got ready=%b reads=%0d want 1/4", req_ready, addr_log.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    load_base_image();
    mem_img[64'h5000] = 64'h6001;
    mem_img[64'h6000] = 64'h7001;
    mem_img[64'h7018] = 64'h8001;
    mem_img[64'h8010] = 64'hABCDE001;
    addr_log.delete();
    exp_q = '{64'h1000, 64'h2000, 64'h3010, 64'h4008, 64'h5000, 64'h6000, 64'h7018, 64'h8010};
    start_req(64'h401ABC, 12'd5, 64'h1000);
    // Second request presented while the first walk is in flight.
    req_valid = 1'b1;
    req_va    = 64'h602123;
    req_pcid  = 12'd9;
    root_base = 64'h5000;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++; $display("FAIL b2b_busy_ready: got %b want 0", req_ready);
    end
    wait_resp(cyc);
    vectors++;
    if (resp_pa !== 64'h99ABC || resp_pcid !== 12'd5) begin
      miscompares++; $display("FAIL b2b_first: got %h/%h want 99abc/5", resp_pa, resp_pcid);
    end
    consume();
    vectors++;
    if (req_ready !== 1'b1 || dbg_state !== 2'd0) begin
      miscompares++; $display("FAIL b2b_gap: got ready=%b state=%0d want 1/0", req_ready, dbg_state);
    end
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (req_ready !== 1'b0 || dbg_state !== 2'd1) begin
      miscompares++; $display("FAIL b2b_accept: got ready=%b state=%0d want 0/1", req_ready, dbg_state);
    end
    wait_resp(cyc);
    vectors++;
    if (cyc !== 9 || resp_pa !== 64'hABCDE123 || resp_pcid !== 12'd9 ||
        resp_va !== 64'h602123 || resp_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: got cyc=%0d pa=%h pcid=%h va=%h f=%b want 9/abcde123/9/602123/0",
               cyc, resp_pa, resp_pcid, resp_va, resp_fault);
    end
    consume();
    while (exp_q.size() > 0 && addr_log.size() > 0) begin
      logic [63:0] e, g;
      e = exp_q.pop_front();
      g = addr_log.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++; $display("FAIL b2b_addr: got %h want %h", g, e);
      end
    end
    vectors++;
    if (exp_q.size() !== 0 || addr_log.size() !== 0) begin
      miscompares++; $display("FAIL b2b_nreads: left exp=%0d got=%0d want 0/0", exp_q.size(), addr_log.size());
    end
  endtask

  task automatic test_reset_in_wait();
    int n;
    load_base_image();
    mem_hold = 1'b1;
    start_req(64'h401ABC, 12'd5, 64'h1000);
    n = 0;
    while (dbg_state !== 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (dbg_state !== 2'd2) begin
      miscompares++; $display("FAIL rstw_reach_wait: got state %0d want 2", dbg_state);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n        = 1'b1;
    mem_hold     = 1'b0;
    inject_stale = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0 || dbg_state !== 2'd0) begin
        miscompares++;
        $display("FAIL rstw_stale: got rv=%b rr=%b mv=%b st=%0d want 0/1/0/0", resp_valid,
                 req_ready, mem_req_valid, dbg_state);
      end
    end
    addr_log.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_va         = '0;
    req_pcid       = '0;
    root_base      = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    resp_ready     = 1'b0;
    mem_hold       = 1'b0;
    inject_stale   = 1'b0;

    test_reset();
    test_base_walk(64'h401ABC, "base");
    test_fault();
    test_stall();
    test_back_to_back();
    test_reset_in_wait();
    test_base_walk(64'h401ABC, "after_rst");
    test_base_walk(64'hFFFF_0000_0040_1ABC, "high_va");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
